interrupt_vector_sequencer: RTL and testbench

- Upstream control stage for the bus preset block.
- Arbitrates reset, NMI, IRQ and BRK, then steps the 7-cycle interrupt entry sequence: stack push of PCH/PCL/P, then vector fetch low/high.
- Drives the one-hot preset selects that force the internal bus to the stack page (0x01) or to a vector byte (0xFA–0xFF), plus stack and vector-load strobes for the datapath.

---
 rtl/interrupt_vector_sequencer.sv | 151 +++++++++++++++
 tb/tb_interrupt_vector_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/interrupt_vector_sequencer.sv
// Interrupt entry sequencer: arbitrates RST/NMI/IRQ/BRK and steps push PCH/PCL/P, vector lo/hi.
// Moore outputs, one step per ready edge; ready=0 freezes the FSM but not the NMI edge detector.
module interrupt_vector_sequencer (
  input  logic clk,
  input  logic nrst,
  input  logic ready,
  input  logic sync,
  input  logic nmi_n,
  input  logic irq_n,
  input  logic brk,
  input  logic i_flag,
  output logic busy,
  output logic set_FF,
  output logic set_FE,
  output logic set_FD,
  output logic set_FC,
  output logic set_FB,
  output logic set_FA,
  output logic set_00,
  output logic set_01,
  output logic stack_we,
  output logic sp_dec,
  output logic b_flag,
  output logic vec_load_lo,
  output logic vec_load_hi,
  output logic set_i
);

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    PUSH_PCH = 3'd2,
    PUSH_PCL = 3'd3,
    PUSH_P   = 3'd4,
    VEC_LO   = 3'd5,
    VEC_HI   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SRC_RST = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } src_t;

  state_t r_state, w_state_nxt;
  src_t   r_src, w_src_nxt;
  logic   r_nmi_prev;
  logic   r_nmi_pend;
  logic   w_nmi_edge;
  logic   w_nmi_clr;

  assign w_nmi_edge = r_nmi_prev & ~nmi_n;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= RST_HOLD;
      r_src      <= SRC_RST;
      r_nmi_prev <= 1'b1;
      r_nmi_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_nmi_prev <= nmi_n;
      // A fresh edge on the clearing clock wins so it is not lost.
      if (w_nmi_edge)
        r_nmi_pend <= 1'b1;
      else if (w_nmi_clr)
        r_nmi_pend <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_nmi_clr   = 1'b0;
    if (ready) begin
      case (r_state)
        RST_HOLD: w_state_nxt = PUSH_PCH;
        IDLE: begin
          if (sync) begin
            if (r_nmi_pend) begin
              w_src_nxt   = SRC_NMI;
              w_state_nxt = PUSH_PCH;
            end else if (brk) begin
              w_src_nxt   = SRC_BRK;
              w_state_nxt = PUSH_PCH;
            end else if (!irq_n && !i_flag) begin
              w_src_nxt   = SRC_IRQ;
              w_state_nxt = PUSH_PCH;
            end
          end
        end
        PUSH_PCH: w_state_nxt = PUSH_PCL;
        PUSH_PCL: w_state_nxt = PUSH_P;
        PUSH_P: begin
          w_state_nxt = VEC_LO;
          // Late NMI hijacks the vector fetch; the pushed B bit is already committed.
          if ((r_src == SRC_IRQ || r_src == SRC_BRK) && r_nmi_pend)
            w_src_nxt = SRC_NMI;
          w_nmi_clr = (w_src_nxt == SRC_NMI);
        end
        VEC_LO:  w_state_nxt = VEC_HI;
        VEC_HI:  w_state_nxt = IDLE;
        default: w_state_nxt = RST_HOLD;
      endcase
    end
  end

  always_comb begin
    busy        = (r_state != IDLE);
    set_FF      = 1'b0;
    set_FE      = 1'b0;
    set_FD      = 1'b0;
    set_FC      = 1'b0;
    set_FB      = 1'b0;
    set_FA      = 1'b0;
    set_01      = 1'b0;
    stack_we    = 1'b0;
    sp_dec      = 1'b0;
    b_flag      = 1'b0;
    vec_load_lo = 1'b0;
    vec_load_hi = 1'b0;
    set_i       = 1'b0;
    case (r_state)
      PUSH_PCH, PUSH_PCL, PUSH_P: begin
        set_01   = 1'b1;
        sp_dec   = 1'b1;
        stack_we = (r_src != SRC_RST);
        b_flag   = (r_state == PUSH_P) && (r_src == SRC_BRK);
      end
      VEC_LO: begin
        vec_load_lo = 1'b1;
        set_FA      = (r_src == SRC_NMI);
        set_FC      = (r_src == SRC_RST);
        set_FE      = (r_src == SRC_IRQ) || (r_src == SRC_BRK);
      end
      VEC_HI: begin
        vec_load_hi = 1'b1;
        set_i       = 1'b1;
        set_FB      = (r_src == SRC_NMI);
        set_FD      = (r_src == SRC_RST);
        set_FF      = (r_src == SRC_IRQ) || (r_src == SRC_BRK);
      end
      default: ;
    endcase
  end

  assign set_00 = 1'b0;

endmodule

// File: tb/tb_interrupt_vector_sequencer.sv
// Bench for interrupt_vector_sequencer: directed vectors, a step/source model compared every cycle,
// plus literal spot checks pinning the expected vector bytes and strobes.
module tb_interrupt_vector_sequencer;

  logic clk = 1'b0;
  logic nrst, ready, sync, nmi_n, irq_n, brk, i_flag;
  logic busy, set_FF, set_FE, set_FD, set_FC, set_FB, set_FA, set_00, set_01;
  logic stack_we, sp_dec, b_flag, vec_load_lo, vec_load_hi, set_i;

  interrupt_vector_sequencer dut (
    .clk(clk), .nrst(nrst), .ready(ready), .sync(sync), .nmi_n(nmi_n),
    .irq_n(irq_n), .brk(brk), .i_flag(i_flag), .busy(busy),
    .set_FF(set_FF), .set_FE(set_FE), .set_FD(set_FD), .set_FC(set_FC),
    .set_FB(set_FB), .set_FA(set_FA), .set_00(set_00), .set_01(set_01),
    .stack_we(stack_we), .sp_dec(sp_dec), .b_flag(b_flag),
    .vec_load_lo(vec_load_lo), .vec_load_hi(vec_load_hi), .set_i(set_i)
  );

  always #5 clk = ~clk;

  localparam int S_RST = 0, S_NMI = 1, S_IRQ = 2, S_BRK = 3;

  // Model: step -1 = reset hold, 0 = idle, 1..3 = pushes, 4 = vector low, 5 = vector high.
  int   m_step = -1;
  int   m_src  = S_RST;
  bit   m_prev = 1'b1;
  bit   m_pend = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   chk_en = 1'b0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_step = -1;
      m_src  = S_RST;
      m_prev = 1'b1;
      m_pend = 1'b0;
    end else begin
      bit edge_seen, clr;
      edge_seen = m_prev && !nmi_n;
      m_prev    = nmi_n;
      clr       = 1'b0;
      if (ready) begin
        if (m_step == -1) m_step = 1;
        else if (m_step == 0) begin
          if (sync) begin
            if (m_pend) begin m_src = S_NMI; m_step = 1; end
            else if (brk) begin m_src = S_BRK; m_step = 1; end
            else if (!irq_n && !i_flag) begin m_src = S_IRQ; m_step = 1; end
          end
        end else if (m_step == 3) begin
          if ((m_src == S_IRQ || m_src == S_BRK) && m_pend) m_src = S_NMI;
          clr    = (m_src == S_NMI);
          m_step = 4;
        end else if (m_step == 5) m_step = 0;
        else m_step = m_step + 1;
      end
      if (edge_seen) m_pend = 1'b1;
      else if (clr) m_pend = 1'b0;
    end
  end

  function automatic logic [7:0] vec_base(input int src);
    if (src == S_NMI) return 8'hFA;
    if (src == S_RST) return 8'hFC;
    return 8'hFE;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0]  sel;
      logic [7:0]  bus, ebus;
      logic [15:0] got, exp;
      bit push;
      sel = {set_FF, set_FE, set_FD, set_FC, set_FB, set_FA, set_00, set_01};
      bus = 8'h00;
      if (set_01) bus = bus | 8'h01;
      if (set_FA) bus = bus | 8'hFA;
      if (set_FB) bus = bus | 8'hFB;
      if (set_FC) bus = bus | 8'hFC;
      if (set_FD) bus = bus | 8'hFD;
      if (set_FE) bus = bus | 8'hFE;
      if (set_FF) bus = bus | 8'hFF;
      push = (m_step >= 1 && m_step <= 3);
      ebus = push ? 8'h01 :
             (m_step == 4) ? vec_base(m_src) :
             (m_step == 5) ? vec_base(m_src) + 8'd1 : 8'h00;
      got = {busy, stack_we, sp_dec, b_flag, vec_load_lo, vec_load_hi, set_i, bus,
             ($countones(sel) <= 1)};
      exp = {(m_step != 0), (push && m_src != S_RST), push, (m_step == 3 && m_src == S_BRK),
             (m_step == 4), (m_step == 5), (m_step == 5), ebus, 1'b1};
      n_vec++;
      if (got !== exp) begin
        n_miss++;
        $display("FAIL outputs t=%0t got=%h want=%h (step %0d src %0d)", $time, got, exp, m_step, m_src);
      end
    end
  end

  task automatic lit(input string nm, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, got, want);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    nrst = 1'b0; ready = 1'b1; sync = 1'b0; nmi_n = 1'b1;
    irq_n = 1'b1; brk = 1'b0; i_flag = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    lit("rst_busy", busy, 1'b1);
    lit("rst_spdec", sp_dec, 1'b0);
    lit("rst_vll", vec_load_lo, 1'b0);

    // Reset sequence: dummy pushes, then FFFC/FFFD.
    nrst = 1'b1;
    tick(1); lit("rs_set01", set_01, 1'b1); lit("rs_we", stack_we, 1'b0);
    tick(3); lit("rs_FC", set_FC, 1'b1);
    tick(1); lit("rs_FD", set_FD, 1'b1); lit("rs_vlh", vec_load_hi, 1'b1);
    tick(1); lit("rs_idle", busy, 1'b0);

    // IRQ taken; deasserting irq_n afterwards does not abort.
    irq_n = 1'b0; i_flag = 1'b0; sync = 1'b1;
    tick(1); sync = 1'b0; irq_n = 1'b1;
    lit("irq_we", stack_we, 1'b1);
    tick(2); lit("irq_bflag", b_flag, 1'b0);
    tick(1); lit("irq_FE", set_FE, 1'b1);
    tick(1); lit("irq_FF", set_FF, 1'b1);
    tick(1);
    // Masked IRQ stays idle.
    i_flag = 1'b1; irq_n = 1'b0; sync = 1'b1;
    tick(2); lit("irq_masked", busy, 1'b0);
    irq_n = 1'b1; sync = 1'b0;

    // BRK: B bit set on the P push.
    brk = 1'b1; sync = 1'b1;
    tick(1); brk = 1'b0; sync = 1'b0;
    tick(2); lit("brk_bflag", b_flag, 1'b1);
    tick(1); lit("brk_FE", set_FE, 1'b1);
    tick(2);

    // NMI hijack of an IRQ during PUSH_PCL.
    i_flag = 1'b0; irq_n = 1'b0; sync = 1'b1;
    tick(1); sync = 1'b0; irq_n = 1'b1;
    tick(1); nmi_n = 1'b0;
    tick(1); nmi_n = 1'b1;
    lit("hij_bflag", b_flag, 1'b0);
    tick(1); lit("hij_FA", set_FA, 1'b1);
    tick(1); lit("hij_FB", set_FB, 1'b1);
    tick(1);
    sync = 1'b1;
    tick(1); lit("hij_cleared", busy, 1'b0);
    sync = 1'b0;

    // Async reset in VEC_LO of a BRK.
    brk = 1'b1; sync = 1'b1;
    tick(1); brk = 1'b0; sync = 1'b0;
    tick(3); lit("ar_pre_vll", vec_load_lo, 1'b1);
    #2 nrst = 1'b0;
    #1 lit("ar_busy", busy, 1'b1); lit("ar_vll", vec_load_lo, 1'b0); lit("ar_FE", set_FE, 1'b0);
    tick(1); nrst = 1'b1;
    tick(2);
    // Stall in PUSH_PCL of the reset sequence with an NMI edge inside the stall.
    ready = 1'b0; nmi_n = 1'b0;
    tick(1); nmi_n = 1'b1;
    tick(3); lit("stall_spdec", sp_dec, 1'b1); lit("stall_01", set_01, 1'b1);
    ready = 1'b1;
    tick(2); lit("stall_FC", set_FC, 1'b1);
    tick(2); lit("stall_idle", busy, 1'b0);
    sync = 1'b1;
    tick(1); sync = 1'b0;
    tick(3); lit("stall_nmi_FA", set_FA, 1'b1);
    tick(2);

    // NMI edge coincident with the sync decision is seen only at the next sync.
    sync = 1'b1; nmi_n = 1'b0;
    tick(1); lit("coinc_idle", busy, 1'b0);
    sync = 1'b0; nmi_n = 1'b1;
    tick(1); sync = 1'b1;
    tick(1); sync = 1'b0; lit("coinc_taken", busy, 1'b1);
    tick(3); lit("coinc_FA", set_FA, 1'b1);
    tick(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
